// File: rtl/aes_round_state_if.sv
// AES-128 state/key datapath bus.
// master: drives kld/key/ld_r/text_in_r/sa_next; slave: returns w0..w3/state/state_sub.
interface aes_round_state_if;
   logic         kld;
   logic [127:0] key;
   logic         ld_r;
   logic [127:0] text_in_r;
   logic [127:0] sa_next;
   logic [31:0]  w0;
   logic [31:0]  w1;
   logic [31:0]  w2;
   logic [31:0]  w3;
   logic [127:0] state;
   logic [127:0] state_sub;

   modport master (
      output kld, key, ld_r, text_in_r, sa_next,
      input  w0, w1, w2, w3, state, state_sub
   );

   modport slave (
      input  kld, key, ld_r, text_in_r, sa_next,
      output w0, w1, w2, w3, state, state_sub
   );
endinterface

// File: rtl/aes_round_state.sv
// AES-128 cipher state register, initial AddRoundKey, on-the-fly key schedule, SubBytes.
// Ports: clk, rst (async, active-high), bus (aes_round_state_if.slave).
module aes_round_state (
   input logic              clk,
   input logic              rst,
   aes_round_state_if.slave bus
);

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0)
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] sq;
      r  = 8'h01;
      sq = gmul(a, a);
      for (int i = 0; i < 7; i++) begin
         r  = gmul(r, sq);
         sq = gmul(sq, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] i;
      i = ginv(a);
      return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]}
               ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] rc(input logic [3:0] n);
      logic [7:0] b;
      b = 8'h00;
      case (n)
         4'd0:    b = 8'h01;
         4'd1:    b = 8'h02;
         4'd2:    b = 8'h04;
         4'd3:    b = 8'h08;
         4'd4:    b = 8'h10;
         4'd5:    b = 8'h20;
         4'd6:    b = 8'h40;
         4'd7:    b = 8'h80;
         4'd8:    b = 8'h1b;
         4'd9:    b = 8'h36;
         default: b = 8'h00;
      endcase
      return {b, 24'h000000};
   endfunction

   logic [127:0] state_q;
   logic [31:0]  w0_q;
   logic [31:0]  w1_q;
   logic [31:0]  w2_q;
   logic [31:0]  w3_q;
   logic [3:0]   rcnt;
   logic [31:0]  rcon;
   logic [31:0]  t;
   logic [3:0]   rcnt_n;
   logic [127:0] sub;

   // RotWord folded into the S-box byte order
   always_comb begin
      t = {sbox(w3_q[23:16]), sbox(w3_q[15:8]),
           sbox(w3_q[7:0]),   sbox(w3_q[31:24])} ^ rcon;
      rcnt_n = rcnt + 4'd1;
   end

   always_comb begin
      sub = '0;
      for (int i = 0; i < 16; i++) begin
         sub[8*i +: 8] = sbox(state_q[8*i +: 8]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w0_q <= '0;
         w1_q <= '0;
         w2_q <= '0;
         w3_q <= '0;
         rcnt <= '0;
         rcon <= '0;
      end else if (bus.kld) begin
         {w0_q, w1_q, w2_q, w3_q} <= bus.key;
         rcnt <= 4'd0;
         rcon <= 32'h01000000;
      end else begin
         w0_q <= w0_q ^ t;
         w1_q <= w0_q ^ w1_q ^ t;
         w2_q <= w0_q ^ w1_q ^ w2_q ^ t;
         w3_q <= w0_q ^ w1_q ^ w2_q ^ w3_q ^ t;
         rcnt <= rcnt_n;
         rcon <= rc(rcnt_n);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= '0;
      end else if (bus.ld_r) begin
         state_q <= bus.text_in_r ^ {w0_q, w1_q, w2_q, w3_q};
      end else begin
         state_q <= bus.sa_next;
      end
   end

   assign bus.w0        = w0_q;
   assign bus.w1        = w1_q;
   assign bus.w2        = w2_q;
   assign bus.w3        = w3_q;
   assign bus.state     = state_q;
   assign bus.state_sub = sub;

endmodule

// File: tb/tb_aes_round_state.sv
// Directed bench for aes_round_state: FIPS-197 vectors, table S-box and key-schedule model.
// Expected values are queued when stimulus is driven and popped at each check.
module tb_aes_round_state;

   logic clk;
   logic rst;
   aes_round_state_if bus ();

   aes_round_state dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [2047:0] SBT = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   localparam logic [7:0] RCT [16] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
      8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] PT    = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] S63   = {16{8'h63}};

   int errors = 0;
   int checks = 0;
   logic [127:0] exp_q [$];

   logic [127:0] mw;
   logic [7:0]   mrcon;
   int           mcnt;

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBT[2047 - 8*int'(b) -: 8];
   endfunction

   function automatic logic [127:0] sub128(input logic [127:0] x);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sb(x[8*i +: 8]);
      return r;
   endfunction

   task automatic m_reset();
      mw = '0;
      mrcon = 8'h00;
      mcnt = 0;
   endtask

   task automatic m_load(input logic [127:0] k);
      mw = k;
      mrcon = 8'h01;
      mcnt = 0;
   endtask

   // FIPS-197 chained word expansion
   task automatic m_step();
      logic [31:0] a, b, c, d, tmp;
      {a, b, c, d} = mw;
      tmp = {sb(d[23:16]), sb(d[15:8]), sb(d[7:0]), sb(d[31:24])};
      tmp = tmp ^ {mrcon, 24'h000000};
      a = a ^ tmp;
      b = b ^ a;
      c = c ^ b;
      d = d ^ c;
      mw = {a, b, c, d};
      mcnt = (mcnt + 1) % 16;
      mrcon = RCT[mcnt];
   endtask

   task automatic push(input logic [127:0] e);
      exp_q.push_back(e);
   endtask

   task automatic chk(input string tag, input logic [127:0] obs);
      logic [127:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
         return;
      end
      e = exp_q.pop_front();
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
   endtask

   function automatic logic [127:0] wcat();
      return {bus.w0, bus.w1, bus.w2, bus.w3};
   endfunction

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [127:0] sa;
      rst = 1'b1;
      bus.kld = 1'b0;
      bus.key = '0;
      bus.ld_r = 1'b0;
      bus.text_in_r = '0;
      bus.sa_next = '0;
      m_reset();
      #3;
      push('0); chk("rst_w", wcat());
      push('0); chk("rst_state", bus.state);
      push(S63); chk("rst_sub", bus.state_sub);
      @(negedge clk);
      rst = 1'b0;

      // FIPS-197 A.1 key, then initial AddRoundKey
      bus.kld = 1'b1;
      bus.key = KEY_A;
      m_load(KEY_A);
      tick();
      push(KEY_A); chk("r0_w", wcat());
      bus.kld = 1'b0;
      bus.ld_r = 1'b1;
      bus.text_in_r = PT;
      tick();
      m_step();
      push(128'ha0fafe1788542cb123a339392a6c7605); chk("r1_w", wcat());
      push(128'h193de3bea0f4e22b9ac68d2ae9f84808); chk("ark_state", bus.state);
      push(128'hd42711aee0bf98f1b8b45de51e415230); chk("ark_sub", bus.state_sub);

      bus.ld_r = 1'b0;
      sa = 128'h00112233445566778899aabbccddeeff;
      bus.sa_next = sa;
      tick();
      m_step();
      push(128'hf2c295f27a96b9435935807a7359f67f); chk("r2_w", wcat());
      push(sa); chk("next_state", bus.state);
      push(sub128(sa)); chk("next_sub", bus.state_sub);
      push(128'h63); chk("s_00", {120'h0, bus.state_sub[127:120]});
      push(128'h82); chk("s_11", {120'h0, bus.state_sub[119:112]});
      push(128'h16); chk("s_ff", {120'h0, bus.state_sub[7:0]});

      // Run past round 10 so RC beyond 0x36 is exercised
      for (int r = 3; r <= 12; r++) begin
         sa = {$urandom, $urandom, $urandom, $urandom};
         bus.sa_next = sa;
         tick();
         m_step();
         if (r == 10) begin
            push(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
            chk("r10_w", wcat());
         end
         push(mw); chk($sformatf("model_w_r%0d", r), wcat());
         push(sa); chk($sformatf("state_r%0d", r), bus.state);
      end

      // Reload mid-schedule at E5
      bus.kld = 1'b1;
      bus.key = KEY_A;
      m_load(KEY_A);
      tick();
      bus.kld = 1'b0;
      for (int r = 1; r <= 4; r++) begin
         tick();
         m_step();
      end
      push(mw); chk("pre_reload_w", wcat());
      bus.kld = 1'b1;
      bus.key = KEY_B;
      m_load(KEY_B);
      tick();
      push(KEY_B); chk("reload_w", wcat());
      bus.kld = 1'b0;
      tick();
      m_step();
      push(128'hd6aa74fdd2af72fadaa678f1d6ab76fe); chk("reload_r1_w", wcat());
      push(mw); chk("reload_model_w", wcat());

      // Every byte value through the state register
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) sa[127 - 8*j -: 8] = 8'(16*i + j);
         bus.sa_next = sa;
         tick();
         m_step();
         push(sub128(sa)); chk($sformatf("sweep_%0d", i), bus.state_sub);
      end
      bus.sa_next = {8'h01, 8'h53, 8'hc9, 104'h0};
      tick();
      m_step();
      push({8'h7c, 8'hed, 8'hdd, {13{8'h63}}}); chk("sbox_points", bus.state_sub);

      // Asynchronous reset mid-cycle
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      m_reset();
      push('0); chk("async_rst_w", wcat());
      push('0); chk("async_rst_state", bus.state);
      push(S63); chk("async_rst_sub", bus.state_sub);
      @(negedge clk);
      rst = 1'b0;
      bus.sa_next = 128'h0f0e0d0c0b0a09080706050403020100;
      tick();
      m_step();
      push(mw); chk("post_rst_w1", wcat());
      push(128'h0f0e0d0c0b0a09080706050403020100); chk("post_rst_state", bus.state);
      tick();
      m_step();
      push(mw); chk("post_rst_w2", wcat());

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
